// File: rtl/button_press_gen.sv
// button_press_gen: synthesizes press/release waveforms on a button line so
// that a downstream press-to-toggle FSM ends up at the requested level.
// Each needed change produces one press of PRESS_CYCLES cycles followed by
// a release of RELEASE_CYCLES cycles. The block then spends at least one
// cycle in IDLE before it can start another press.
module button_press_gen #(
    parameter int PRESS_CYCLES   = 4,
    parameter int RELEASE_CYCLES = 4,
    parameter int CW             = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          target,
    output logic          button,
    output logic          level,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] press_count,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CW-1:0] C_PRESS_LOAD   = CW'(PRESS_CYCLES - 1);
    localparam logic [CW-1:0] C_RELEASE_LOAD = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE          = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_button;
    logic          r_level;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_press_count;

    // Sequencer: target is only looked at in IDLE, so changes that arrive
    // while a press or release is running are not latched. The level model
    // flips together with the rising button edge, because that is when the
    // downstream FSM sees the press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_button      <= 1'b0;
            r_level       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_press_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (target != r_level) begin
                        r_state       <= PRESS;
                        r_button      <= 1'b1;
                        r_busy        <= 1'b1;
                        r_level       <= ~r_level;
                        r_press_count <= r_press_count + C_ONE;
                        r_cnt         <= C_PRESS_LOAD;
                    end
                end
                PRESS: begin
                    if (r_cnt == '0) begin
                        r_state  <= RELEASE;
                        r_button <= 1'b0;
                        r_cnt    <= C_RELEASE_LOAD;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                RELEASE: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - C_ONE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_button <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

    assign button      = r_button;
    assign level       = r_level;
    assign busy        = r_busy;
    assign done        = r_done;
    assign press_count = r_press_count;
    assign dbg_state   = r_state;

endmodule
